// File: rtl/bp_cce_hybrid_pending_counters_pkg.sv
// bp_cce_hybrid_pending_counters_pkg: shared drain-FSM type and index helpers for the pending-counter store
package bp_cce_hybrid_pending_counters_pkg;
  typedef enum logic [1:0] {e_pend_idle, e_pend_drain, e_pend_done} bp_cce_pend_drain_state_e;
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Bank hashing strips the bank-select part of the way-group number, leaving the per-CCE index
  function automatic logic [31:0] hash_index(input logic [31:0] rev, input int unsigned banks);
    return rev / banks;
  endfunction
endpackage

// File: rtl/bp_cce_hybrid_pending_counters_if.sv
// bp_cce_hybrid_pending_counters_if: write, read, drain and error signals of the pending-counter store
interface bp_cce_hybrid_pending_counters_if #(
  parameter int paddr_width_p  = 16,
  parameter int width_p        = 3,
  parameter int num_rd_ports_p = 2
);
  logic                                     inc_v_i;
  logic [paddr_width_p-1:0]                 inc_addr_i;
  logic                                     inc_bypass_i;
  logic                                     inc_ready_o;
  logic                                     dec_v_i;
  logic [paddr_width_p-1:0]                 dec_addr_i;
  logic                                     dec_bypass_i;
  logic                                     clr_v_i;
  logic [paddr_width_p-1:0]                 clr_addr_i;
  logic                                     clr_bypass_i;
  logic [num_rd_ports_p-1:0]                r_v_i;
  logic [num_rd_ports_p*paddr_width_p-1:0]  r_addr_i;
  logic [num_rd_ports_p-1:0]                r_bypass_i;
  logic [num_rd_ports_p-1:0]                pending_o;
  logic [num_rd_ports_p*width_p-1:0]        count_o;
  logic                                     any_pending_o;
  logic                                     drain_v_i;
  logic                                     drain_ready_o;
  logic                                     drain_done_o;
  logic                                     err_o;
  logic                                     err_clr_i;
  modport master (
    output inc_v_i, inc_addr_i, inc_bypass_i, dec_v_i, dec_addr_i, dec_bypass_i,
           clr_v_i, clr_addr_i, clr_bypass_i, r_v_i, r_addr_i, r_bypass_i, drain_v_i, err_clr_i,
    input  inc_ready_o, pending_o, count_o, any_pending_o, drain_ready_o, drain_done_o, err_o
  );
  modport slave (
    input  inc_v_i, inc_addr_i, inc_bypass_i, dec_v_i, dec_addr_i, dec_bypass_i,
           clr_v_i, clr_addr_i, clr_bypass_i, r_v_i, r_addr_i, r_bypass_i, drain_v_i, err_clr_i,
    output inc_ready_o, pending_o, count_o, any_pending_o, drain_ready_o, drain_done_o, err_o
  );
endinterface

// File: rtl/bp_cce_hybrid_pending_wg_index.sv
// bp_cce_hybrid_pending_wg_index: maps an address to a local way-group number, flagging out-of-range groups
module bp_cce_hybrid_pending_wg_index
  import bp_cce_hybrid_pending_counters_pkg::*;
#(
  parameter  int paddr_width_p    = 16,
  parameter  int addr_offset_p    = 4,
  parameter  int cce_way_groups_p = 32,
  parameter  int num_cce_p        = 2,
  parameter  int num_way_groups_p = 12,
  localparam int lg_wg_lp         = safe_clog2(num_way_groups_p),
  localparam int lg_cce_wg_lp     = safe_clog2(cce_way_groups_p)
) (
  input  logic [paddr_width_p-1:0] addr_i,
  input  logic                     bypass_i,
  output logic [lg_wg_lp-1:0]      wg_o,
  output logic                     v_o
);
  logic [lg_cce_wg_lp-1:0] fld, rev;
  logic [31:0]             idx;
  assign fld = addr_i[addr_offset_p+:lg_cce_wg_lp];
  for (genvar i = 0; i < lg_cce_wg_lp; i++) begin : g_rev
    assign rev[i] = fld[lg_cce_wg_lp-1-i];
  end
  assign idx  = bypass_i ? 32'(addr_i[lg_wg_lp-1:0]) : hash_index(32'(rev), num_cce_p);
  assign wg_o = idx[lg_wg_lp-1:0];
  assign v_o  = idx < 32'(num_way_groups_p);
endmodule

// File: rtl/bp_cce_hybrid_pending_counters.sv
// bp_cce_hybrid_pending_counters: saturating pending counters per way group with inc/dec/clr ports, reads and drain FSM
module bp_cce_hybrid_pending_counters
  import bp_cce_hybrid_pending_counters_pkg::*;
#(
  parameter int num_way_groups_p = 12,
  parameter int cce_way_groups_p = 32,
  parameter int num_cce_p        = 2,
  parameter int paddr_width_p    = 16,
  parameter int addr_offset_p    = 4,
  parameter int width_p          = 3,
  parameter int num_rd_ports_p   = 2,
  parameter int forward_p        = 0
) (
  input logic                          clk_i,
  input logic                          reset_n_i,
  bp_cce_hybrid_pending_counters_if.slave io
);
  localparam int lg_wg_lp   = safe_clog2(num_way_groups_p);
  localparam int num_idx_lp = 3 + num_rd_ports_p;
  localparam logic [width_p-1:0] max_lp = '1;

  bp_cce_pend_drain_state_e      state_q, state_n;
  logic [width_p-1:0]            cnt_q [num_way_groups_p];
  logic [width_p-1:0]            cnt_n [num_way_groups_p];
  logic [width_p:0]              sum   [num_way_groups_p];
  logic [num_way_groups_p-1:0]   hc, hi, hd, uf;
  logic [paddr_width_p-1:0]      idx_addr [num_idx_lp];
  logic [lg_wg_lp-1:0]           idx_wg   [num_idx_lp];
  logic [num_idx_lp-1:0]         idx_byp, idx_v;
  logic                          inc_v, dec_v, clr_v, inc_fire, any_pending, idle, err_q;

  // Index slots: 0 inc, 1 dec, 2 clr, then one per read port
  assign idx_addr[0]  = io.inc_addr_i;
  assign idx_addr[1]  = io.dec_addr_i;
  assign idx_addr[2]  = io.clr_addr_i;
  assign idx_byp[2:0] = {io.clr_bypass_i, io.dec_bypass_i, io.inc_bypass_i};
  for (genvar r = 0; r < num_rd_ports_p; r++) begin : g_rd_idx
    assign idx_addr[3+r] = io.r_addr_i[r*paddr_width_p+:paddr_width_p];
    assign idx_byp[3+r]  = io.r_bypass_i[r];
  end
  for (genvar k = 0; k < num_idx_lp; k++) begin : g_idx
    bp_cce_hybrid_pending_wg_index #(
      .paddr_width_p(paddr_width_p), .addr_offset_p(addr_offset_p),
      .cce_way_groups_p(cce_way_groups_p), .num_cce_p(num_cce_p), .num_way_groups_p(num_way_groups_p)
    ) idx (.addr_i(idx_addr[k]), .bypass_i(idx_byp[k]), .wg_o(idx_wg[k]), .v_o(idx_v[k]));
  end

  assign inc_v = io.inc_v_i & idx_v[0];
  assign dec_v = io.dec_v_i & idx_v[1];
  assign clr_v = io.clr_v_i & idx_v[2];
  // A saturated target still accepts when a same-cycle dec or clr makes room
  assign io.inc_ready_o = idle & (~idx_v[0] | (cnt_q[idx_wg[0]] != max_lp)
                        | (dec_v & (idx_wg[1] == idx_wg[0])) | (clr_v & (idx_wg[2] == idx_wg[0])));
  assign inc_fire = inc_v & io.inc_ready_o;

  // sum can reach max+1 only alongside a dec, whose wrap-around subtract lands back on max
  always_comb begin
    for (int i = 0; i < num_way_groups_p; i++) begin
      hc[i]    = clr_v & (idx_wg[2] == lg_wg_lp'(i));
      hi[i]    = inc_fire & (idx_wg[0] == lg_wg_lp'(i));
      hd[i]    = dec_v & (idx_wg[1] == lg_wg_lp'(i));
      sum[i]   = {1'b0, (hc[i] ? {width_p{1'b0}} : cnt_q[i])} + (width_p+1)'(hi[i]);
      cnt_n[i] = sum[i][width_p-1:0] - width_p'(hd[i] & (sum[i] != '0));
      uf[i]    = hd[i] & ~hc[i] & (sum[i] == '0);
    end
  end

  always_ff @(posedge clk_i)
    for (int i = 0; i < num_way_groups_p; i++) cnt_q[i] <= reset_n_i ? cnt_n[i] : '0;

  always_comb begin
    any_pending = 1'b0;
    for (int i = 0; i < num_way_groups_p; i++) any_pending = any_pending | (cnt_q[i] != '0);
  end
  assign io.any_pending_o = any_pending;

  always_ff @(posedge clk_i) state_q <= reset_n_i ? state_n : e_pend_idle;

  always_comb
    state_n = (state_q == e_pend_idle)  ? (io.drain_v_i ? e_pend_drain : e_pend_idle)
            : (state_q == e_pend_drain) ? (any_pending ? e_pend_drain : e_pend_done)
            : e_pend_idle;

  always_comb begin
    idle             = state_q == e_pend_idle;
    io.drain_ready_o = idle;
    io.drain_done_o  = state_q == e_pend_done;
  end

  always_ff @(posedge clk_i) err_q <= reset_n_i & ((|uf) | (err_q & ~io.err_clr_i));
  assign io.err_o = err_q;

  for (genvar r = 0; r < num_rd_ports_p; r++) begin : g_rd
    logic [width_p-1:0] val;
    assign val = (io.r_v_i[r] & idx_v[3+r])
               ? ((forward_p != 0) ? cnt_n[idx_wg[3+r]] : cnt_q[idx_wg[3+r]]) : '0;
    assign io.count_o[r*width_p+:width_p] = val;
    assign io.pending_o[r] = |val;
  end
endmodule

// File: tb/tb_bp_cce_hybrid_pending_counters.sv
// tb_bp_cce_hybrid_pending_counters: vector table, drain/reset sequences and random reads against a counter model
module tb_bp_cce_hybrid_pending_counters;
  localparam int NWG = 12;
  localparam int MAXC = 3;

  typedef struct packed {
    logic inc_v; logic [15:0] inc_a; logic inc_b;
    logic dec_v; logic [15:0] dec_a; logic dec_b;
    logic clr_v; logic [15:0] clr_a; logic clr_b;
    logic [3:0] r_v; logic [63:0] r_a; logic [3:0] r_b;
    logic drain_v; logic err_clr;
  } stim_t;

  typedef struct {
    int iv; int iw; int dv; int dw; int cv; int cw; int ec; int rw;
    int rdy; int cnt; int err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  stim_t st;
  int checks = 0;
  int errors = 0;
  vec_t tv[$];
  int m[NWG];
  int n[NWG];
  int errm;

  always #5 clk = ~clk;

  bp_cce_hybrid_pending_counters_if #(.paddr_width_p(16), .width_p(2), .num_rd_ports_p(4)) ifs [2] ();

  for (genvar d = 0; d < 2; d++) begin : g_dut
    assign ifs[d].inc_v_i      = st.inc_v;
    assign ifs[d].inc_addr_i   = st.inc_a;
    assign ifs[d].inc_bypass_i = st.inc_b;
    assign ifs[d].dec_v_i      = st.dec_v;
    assign ifs[d].dec_addr_i   = st.dec_a;
    assign ifs[d].dec_bypass_i = st.dec_b;
    assign ifs[d].clr_v_i      = st.clr_v;
    assign ifs[d].clr_addr_i   = st.clr_a;
    assign ifs[d].clr_bypass_i = st.clr_b;
    assign ifs[d].r_v_i        = st.r_v;
    assign ifs[d].r_addr_i     = st.r_a;
    assign ifs[d].r_bypass_i   = st.r_b;
    assign ifs[d].drain_v_i    = st.drain_v;
    assign ifs[d].err_clr_i    = st.err_clr;
    bp_cce_hybrid_pending_counters #(
      .num_way_groups_p(NWG), .cce_way_groups_p(32), .num_cce_p(2), .paddr_width_p(16),
      .addr_offset_p(4), .width_p(2), .num_rd_ports_p(4), .forward_p(d)
    ) dut (.clk_i(clk), .reset_n_i(rst_n), .io(ifs[d]));
  end

  logic [7:0] c0, c1;
  logic [3:0] p0, p1;
  logic rdy0, err0, any0, dr0, dd0;
  assign c0   = ifs[0].count_o;
  assign c1   = ifs[1].count_o;
  assign p0   = ifs[0].pending_o;
  assign p1   = ifs[1].pending_o;
  assign rdy0 = ifs[0].inc_ready_o;
  assign err0 = ifs[0].err_o;
  assign any0 = ifs[0].any_pending_o;
  assign dr0  = ifs[0].drain_ready_o;
  assign dd0  = ifs[0].drain_done_o;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic int rd(input logic [7:0] c, input int p);
    return int'(c[p*2+:2]);
  endfunction

  // Way group from the address: bypass takes low bits; otherwise reverse the 5-bit field at bit 4 and divide by the 2 CCE banks
  function automatic int wg_of(input logic [15:0] a, input logic b);
    int f, rv;
    if (b) return int'(a[3:0]);
    f = int'(a[8:4]);
    rv = 0;
    for (int k = 0; k < 5; k++) if ((f & (1 << k)) != 0) rv += 1 << (4 - k);
    return rv / 2;
  endfunction

  task automatic do_reset;
    st = '0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic set_inc(input int w);
    st.inc_v = 1'b1; st.inc_a = 16'(w); st.inc_b = 1'b1;
  endtask

  task automatic set_dec(input int w);
    st.dec_v = 1'b1; st.dec_a = 16'(w); st.dec_b = 1'b1;
  endtask

  task automatic read0(input int w);
    st.r_v[0] = 1'b1; st.r_a[15:0] = 16'(w); st.r_b[0] = 1'b1;
  endtask

  task automatic rand_addr(output logic [15:0] a, output logic b);
    b = $urandom_range(0, 3) != 0;
    a = b ? 16'($urandom_range(0, 13)) : 16'($urandom);
  endtask

  initial begin
    st = '0;
    do_reset;
    #1;
    chk("reset drain_ready", int'(dr0), 1);
    chk("reset drain_done", int'(dd0), 0);
    chk("reset any_pending", int'(any0), 0);
    chk("reset inc_ready", int'(rdy0), 1);
    chk("reset err", int'(err0), 0);

    // iv iw dv dw cv cw ec rw | rdy cnt err
    tv.push_back('{1, 5, 0, 0, 0, 0, 0, 5, 1, 1, 0});
    tv.push_back('{1, 5, 0, 0, 0, 0, 0, 5, 1, 2, 0});
    tv.push_back('{1, 5, 0, 0, 0, 0, 0, 5, 1, 3, 0});
    tv.push_back('{1, 5, 0, 0, 0, 0, 0, 5, 0, 3, 0});
    tv.push_back('{1, 5, 1, 5, 0, 0, 0, 5, 1, 3, 0});
    tv.push_back('{1, 2, 0, 0, 0, 0, 0, 2, 1, 1, 0});
    tv.push_back('{1, 2, 0, 0, 0, 0, 0, 2, 1, 2, 0});
    tv.push_back('{1, 2, 0, 0, 0, 0, 0, 2, 1, 3, 0});
    tv.push_back('{1, 2, 0, 0, 1, 2, 0, 2, 1, 1, 0});
    tv.push_back('{1, 2, 1, 2, 1, 2, 0, 2, 1, 0, 0});
    tv.push_back('{0, 0, 1, 7, 0, 0, 0, 7, 1, 0, 1});
    tv.push_back('{0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0});
    tv.push_back('{0, 0, 1, 7, 0, 0, 1, 7, 1, 0, 1});
    tv.push_back('{0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0});
    tv.push_back('{1, 13, 0, 0, 0, 0, 0, 13, 1, 0, 0});
    tv.push_back('{0, 0, 1, 13, 0, 0, 0, 13, 1, 0, 0});
    for (int i = 0; i < tv.size(); i++) begin
      st = '0;
      st.inc_v = tv[i].iv != 0; st.inc_a = 16'(tv[i].iw); st.inc_b = 1'b1;
      st.dec_v = tv[i].dv != 0; st.dec_a = 16'(tv[i].dw); st.dec_b = 1'b1;
      st.clr_v = tv[i].cv != 0; st.clr_a = 16'(tv[i].cw); st.clr_b = 1'b1;
      st.err_clr = tv[i].ec != 0;
      read0(tv[i].rw);
      #1;
      chk($sformatf("vec%0d inc_ready", i), int'(rdy0), tv[i].rdy);
      chk($sformatf("vec%0d fwd count", i), rd(c1, 0), tv[i].cnt);
      tick;
      chk($sformatf("vec%0d count", i), rd(c0, 0), tv[i].cnt);
      chk($sformatf("vec%0d err", i), int'(err0), tv[i].err);
    end

    // forwarded vs registered read of a same-cycle increment
    st = '0;
    set_inc(1);
    st.r_v[1] = 1'b1; st.r_a[31:16] = 16'd1; st.r_b[1] = 1'b1;
    #1;
    chk("fwd pending same cycle", int'(p1[1]), 1);
    chk("reg pending same cycle", int'(p0[1]), 0);
    tick;
    chk("reg pending next cycle", int'(p0[1]), 1);

    // drain with wg0=2, wg3=1: increments blocked, done one cycle after the counters empty
    do_reset;
    set_inc(0); tick; tick;
    set_inc(3); tick;
    st = '0; st.drain_v = 1'b1;
    #1;
    chk("drain ready idle", int'(dr0), 1);
    tick;
    st = '0;
    set_inc(4);
    #1;
    chk("drain inc_ready", int'(rdy0), 0);
    chk("drain ready busy", int'(dr0), 0);
    chk("drain any_pending", int'(any0), 1);
    for (int i = 0; i < 3; i++) begin
      set_dec(i < 2 ? 0 : 3);
      #1;
      chk($sformatf("drain dec%0d inc_ready", i), int'(rdy0), 0);
      tick;
    end
    st.dec_v = 1'b0;
    chk("drain last dec no done", int'(dd0), 0);
    chk("drain emptied", int'(any0), 0);
    tick;
    chk("drain done pulse", int'(dd0), 1);
    chk("drain done inc_ready", int'(rdy0), 0);
    tick;
    st = '0;
    read0(4);
    #1;
    chk("drain done one cycle", int'(dd0), 0);
    chk("drain back idle", int'(dr0), 1);
    chk("drain blocked inc", rd(c0, 0), 0);

    // drain with everything already zero
    st = '0; st.drain_v = 1'b1;
    tick;
    st.drain_v = 1'b0;
    #1;
    chk("zero drain in drain", int'(dd0), 0);
    tick;
    chk("zero drain done", int'(dd0), 1);
    tick;
    chk("zero drain idle", int'(dr0), 1);

    // reset while draining aborts without a done pulse
    st = '0;
    set_inc(6); tick; tick;
    st = '0; st.drain_v = 1'b1; tick;
    st = '0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    read0(6);
    #1;
    chk("abort drain_ready", int'(dr0), 1);
    chk("abort drain_done", int'(dd0), 0);
    chk("abort any_pending", int'(any0), 0);
    chk("abort count", rd(c0, 0), 0);
    tick;
    chk("abort no late done", int'(dd0), 0);

    // randomized traffic against the counter model
    do_reset;
    for (int g = 0; g < NWG; g++) m[g] = 0;
    errm = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int iw, dw, cw, rw, v, e0, e1, er, ex_any;
      logic [15:0] a;
      logic b, fire, uf;
      st = '0;
      st.inc_v = $urandom_range(0, 99) < 60;
      rand_addr(a, b); st.inc_a = a; st.inc_b = b;
      st.dec_v = $urandom_range(0, 99) < 40;
      rand_addr(a, b); st.dec_a = a; st.dec_b = b;
      st.clr_v = $urandom_range(0, 99) < 10;
      rand_addr(a, b); st.clr_a = a; st.clr_b = b;
      st.err_clr = $urandom_range(0, 9) == 0;
      st.r_v = 4'($urandom);
      for (int p = 0; p < 4; p++) begin
        rand_addr(a, b);
        st.r_a[p*16+:16] = a; st.r_b[p] = b;
      end
      iw = wg_of(st.inc_a, st.inc_b);
      dw = (st.dec_v && wg_of(st.dec_a, st.dec_b) < NWG) ? wg_of(st.dec_a, st.dec_b) : -1;
      cw = (st.clr_v && wg_of(st.clr_a, st.clr_b) < NWG) ? wg_of(st.clr_a, st.clr_b) : -1;
      er = (iw >= NWG || m[iw] < MAXC || dw == iw || cw == iw) ? 1 : 0;
      fire = st.inc_v && er == 1 && iw < NWG;
      uf = 1'b0;
      for (int g = 0; g < NWG; g++) begin
        v = (cw == g) ? 0 : m[g];
        if (fire && iw == g) v++;
        if (dw == g) begin
          if (v == 0) uf = uf | (cw != g);
          else v--;
        end
        n[g] = v;
      end
      ex_any = 0;
      for (int g = 0; g < NWG; g++) if (m[g] != 0) ex_any = 1;
      #1;
      chk($sformatf("rnd%0d inc_ready", cyc), int'(rdy0), er);
      chk($sformatf("rnd%0d any_pending", cyc), int'(any0), ex_any);
      for (int p = 0; p < 4; p++) begin
        rw = wg_of(st.r_a[p*16+:16], st.r_b[p]);
        e0 = (st.r_v[p] && rw < NWG) ? m[rw] : 0;
        e1 = (st.r_v[p] && rw < NWG) ? n[rw] : 0;
        chk($sformatf("rnd%0d reg count p%0d", cyc, p), rd(c0, p), e0);
        chk($sformatf("rnd%0d fwd count p%0d", cyc, p), rd(c1, p), e1);
        chk($sformatf("rnd%0d pending p%0d", cyc, p), int'(p0[p]), (e0 != 0) ? 1 : 0);
      end
      tick;
      errm = uf ? 1 : (st.err_clr ? 0 : errm);
      m = n;
      chk($sformatf("rnd%0d err", cyc), int'(err0), errm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
